// File: rtl/demux_1to4_stream_pkg.sv
// Shared constants and helpers for the 1-to-4 stream demultiplexer.
package demux_1to4_stream_pkg;

   localparam int NUM_PORTS = 4;
   localparam int SEL_W     = 2;

   // One-hot decode of a destination index into a per-port strobe vector.
   function automatic logic [NUM_PORTS-1:0] onehot_decode(input logic [SEL_W-1:0] sel);
      logic [NUM_PORTS-1:0] dec;
      dec = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         dec[i] = (sel == SEL_W'(i));
      end
      return dec;
   endfunction

endpackage

// File: rtl/stream_slot_reg.sv
// One-entry valid/ready holding register: load, drain or hold each cycle.
module stream_slot_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             drain,
   output logic             full,
   output logic [WIDTH-1:0] data
);

   logic             full_reg;
   logic [WIDTH-1:0] data_reg;

   // A load wins over a drain so a beat can be replaced while it leaves (full throughput).
   always_ff @(posedge clk) begin
      if (srst) begin
         full_reg <= 1'b0;
         data_reg <= '0;
      end else if (load) begin
         full_reg <= 1'b1;
         data_reg <= load_data;
      end else if (drain && full_reg) begin
         full_reg <= 1'b0;
      end
   end

   assign full = full_reg;
   assign data = data_reg;

endmodule

// File: rtl/demux_1to4_stream.sv
// Routes each accepted input beat to one of four one-entry output buffers.
module demux_1to4_stream
   import demux_1to4_stream_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic [SEL_W-1:0]     i_Select,
   input  logic [WIDTH-1:0]     i_Data,
   input  logic                 i_Valid,
   output logic                 o_Ready,
   output logic [WIDTH-1:0]     o_Data0,
   output logic [WIDTH-1:0]     o_Data1,
   output logic [WIDTH-1:0]     o_Data2,
   output logic [WIDTH-1:0]     o_Data3,
   output logic [NUM_PORTS-1:0] o_Valid,
   input  logic [NUM_PORTS-1:0] i_Ready
);

   logic [NUM_PORTS-1:0] full;
   logic [NUM_PORTS-1:0] load_vec;
   logic [WIDTH-1:0]     slot_data [NUM_PORTS];
   logic                 in_xfer;

   // Only the addressed buffer matters for acceptance, so a stalled port never
   // blocks beats headed elsewhere. Ready never looks at i_Valid.
   assign o_Ready  = ~i_Reset & (~full[i_Select] | i_Ready[i_Select]);
   assign in_xfer  = i_Valid & o_Ready;
   assign load_vec = in_xfer ? onehot_decode(i_Select) : '0;

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
         stream_slot_reg #(
            .WIDTH(WIDTH)
         ) u_slot (
            .clk      (i_Clock),
            .srst     (i_Reset),
            .load     (load_vec[gi]),
            .load_data(i_Data),
            .drain    (i_Ready[gi]),
            .full     (full[gi]),
            .data     (slot_data[gi])
         );
      end
   endgenerate

   assign o_Valid = full;
   assign o_Data0 = slot_data[0];
   assign o_Data1 = slot_data[1];
   assign o_Data2 = slot_data[2];
   assign o_Data3 = slot_data[3];

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Self-checking bench: per-port FIFO reference model with directed and random stimulus.
module tb_demux_1to4_stream;

   logic        clk;
   logic        i_Reset;
   logic [1:0]  i_Select;
   logic [31:0] i_Data;
   logic        i_Valid;
   logic        o_Ready;
   logic [31:0] o_Data0, o_Data1, o_Data2, o_Data3;
   logic [3:0]  o_Valid;
   logic [3:0]  i_Ready;
   logic [31:0] od [4];

   int total = 0;
   int bad   = 0;

   // Reference: each port is an ordered queue of beats still owed to its sink.
   logic [31:0] q [4][$];
   int          deliv_cnt [4];
   int          accept_cnt [4];

   demux_1to4_stream #(.WIDTH(32)) dut (
      .i_Clock (clk),
      .i_Reset (i_Reset),
      .i_Select(i_Select),
      .i_Data  (i_Data),
      .i_Valid (i_Valid),
      .o_Ready (o_Ready),
      .o_Data0 (o_Data0),
      .o_Data1 (o_Data1),
      .o_Data2 (o_Data2),
      .o_Data3 (o_Data3),
      .o_Valid (o_Valid),
      .i_Ready (i_Ready)
   );

   assign od[0] = o_Data0;
   assign od[1] = o_Data1;
   assign od[2] = o_Data2;
   assign od[3] = o_Data3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, compare outputs against the model, then advance the model at the edge.
   task automatic cycle(input logic [1:0] sel, input logic [31:0] d, input logic v,
                        input logic [3:0] r, input logic rs);
      logic [3:0] exp_valid;
      logic       exp_ready;
      i_Select = sel;
      i_Data   = d;
      i_Valid  = v;
      i_Ready  = r;
      i_Reset  = rs;
      #1;
      for (int n = 0; n < 4; n++) exp_valid[n] = (q[n].size() > 0);
      exp_ready = !rs && ((q[sel].size() == 0) || r[sel]);
      chk("o_valid", {28'd0, o_Valid}, {28'd0, exp_valid});
      chk("o_ready", {31'd0, o_Ready}, {31'd0, exp_ready});
      for (int n = 0; n < 4; n++) begin
         if (q[n].size() > 0) chk($sformatf("o_data%0d", n), od[n], q[n][0]);
      end
      $display("cyc t=%0t rst=%0b sel=%0d data=%h v=%0b rdy=%b | o_valid=%b o_ready=%0b",
               $time, rs, sel, d, v, r, o_Valid, o_Ready);
      @(posedge clk);
      if (rs) begin
         for (int n = 0; n < 4; n++) q[n].delete();
      end else begin
         for (int n = 0; n < 4; n++) begin
            if (q[n].size() > 0 && r[n]) begin
               void'(q[n].pop_front());
               deliv_cnt[n]++;
            end
         end
         if (v && exp_ready) begin
            q[sel].push_back(d);
            accept_cnt[sel]++;
         end
      end
      #1;
   endtask

   initial begin
      int acc;
      int cyc;
      int d0;
      for (int n = 0; n < 4; n++) begin
         deliv_cnt[n]  = 0;
         accept_cnt[n] = 0;
      end
      i_Reset = 1'b1; i_Select = '0; i_Data = '0; i_Valid = 1'b0; i_Ready = '0;
      @(posedge clk); #1;

      // Reset: two cycles with a beat presented, which must be refused.
      cycle(2'd1, 32'h1111_1111, 1'b1, 4'b0000, 1'b1);
      cycle(2'd1, 32'h1111_1111, 1'b1, 4'b0000, 1'b1);
      for (int n = 0; n < 4; n++) chk($sformatf("rst_data%0d", n), od[n], 32'd0);
      chk("rst_valid", {28'd0, o_Valid}, 32'd0);

      // Single beat to port 2, first cycle after reset.
      cycle(2'd2, 32'hDEADBEEF, 1'b1, 4'b1111, 1'b0);
      chk("single_valid", {28'd0, o_Valid}, 32'h4);
      chk("single_data2", o_Data2, 32'hDEADBEEF);
      cycle(2'd0, 32'h0, 1'b0, 4'b1111, 1'b0);

      // Fill all four ports with sinks stalled.
      for (int n = 0; n < 4; n++) cycle(n[1:0], 32'(n + 1), 1'b1, 4'b0000, 1'b0);
      chk("fill_valid", {28'd0, o_Valid}, 32'hF);
      for (int n = 0; n < 4; n++) chk($sformatf("fill_data%0d", n), od[n], 32'(n + 1));

      // Full stalled port 1 blocks only its own beats.
      cycle(2'd0, 32'h0, 1'b0, 4'b1101, 1'b0);
      i_Select = 2'd1; i_Ready = 4'b0000; #1;
      chk("blk_ready_p1", {31'd0, o_Ready}, 32'd0);
      cycle(2'd1, 32'h55, 1'b1, 4'b0000, 1'b0);
      i_Select = 2'd3; #1;
      chk("blk_ready_p3", {31'd0, o_Ready}, 32'd1);
      cycle(2'd3, 32'h33, 1'b1, 4'b0000, 1'b0);
      chk("blk_data3", o_Data3, 32'h33);
      chk("blk_data1", o_Data1, 32'd2);
      cycle(2'd0, 32'h0, 1'b0, 4'b1111, 1'b0);

      // Port 0 streaming at full rate.
      d0 = deliv_cnt[0];
      for (int k = 0; k < 8; k++) cycle(2'd0, 32'(10 + k), 1'b1, 4'b0001, 1'b0);
      cycle(2'd0, 32'h0, 1'b0, 4'b0001, 1'b0);
      chk("stream_deliv", 32'(deliv_cnt[0] - d0), 32'd8);

      // Port 2 with a sink toggling ready: 16 random beats, bounded.
      acc = accept_cnt[2];
      cyc = 0;
      while ((accept_cnt[2] - acc) < 16 && cyc < 200) begin
         cycle(2'd2, $urandom, 1'($urandom_range(0, 3) != 0), {1'b0, cyc[0], 2'b00}, 1'b0);
         cyc++;
      end
      chk("p2_accepted", 32'(accept_cnt[2] - acc), 32'd16);
      for (int k = 0; k < 4; k++) cycle(2'd0, 32'h0, 1'b0, 4'b1111, 1'b0);
      chk("p2_drained", 32'(deliv_cnt[2]), 32'(accept_cnt[2]));

      // Random mixed traffic; invalid cycles carry junk select/data.
      for (int k = 0; k < 80; k++) begin
         cycle(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 1'b0);
      end
      for (int k = 0; k < 3; k++) cycle(2'd0, 32'h0, 1'b0, 4'b1111, 1'b0);
      for (int n = 0; n < 4; n++)
         chk($sformatf("rand_balance%0d", n), 32'(deliv_cnt[n]), 32'(accept_cnt[n]));

      // Reset mid-operation discards buffered beats.
      cycle(2'd0, 32'hA0, 1'b1, 4'b0000, 1'b0);
      cycle(2'd1, 32'hA1, 1'b1, 4'b0000, 1'b0);
      cycle(2'd3, 32'hA3, 1'b1, 4'b0000, 1'b0);
      chk("pre_rst_valid", {28'd0, o_Valid}, 32'hB);
      cycle(2'd2, 32'hA2, 1'b1, 4'b0000, 1'b1);
      chk("post_rst_valid", {28'd0, o_Valid}, 32'd0);
      i_Select = 2'd1; i_Reset = 1'b0; i_Ready = 4'b1111; #1;
      chk("post_rst_ready", {31'd0, o_Ready}, 32'd1);
      cycle(2'd1, 32'hBEEF, 1'b1, 4'b1111, 1'b0);
      chk("post_rst_beat", o_Data1, 32'hBEEF);
      for (int k = 0; k < 3; k++) cycle(2'd0, 32'h0, 1'b0, 4'b1111, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
